pipeline_retire_trace: RTL and testbench

Retirement trace writer for the 5-stage MIPS pipeline: it sits on the write-back stage, captures one record per retiring instruction, and buffers the records in a FIFO. A consumer drains them over a valid/ready handshake, either a simulation monitor or a future debug port. It is the producer side of the per-cycle PC/instruction trace that the CPU bench prints. Records carry a cycle stamp, PC, raw instruction, decoded instruction class and register write-back data.

---
 rtl/pipeline_retire_trace.sv | 215 +++++++++++++++++++++
 tb/tb_pipeline_retire_trace.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_retire_trace.sv
// Write-back retirement trace: decodes each retiring instruction into a stamped record and queues it.
// One-cycle push latency, first-word fall-through head; pushes into a full queue with no pop are dropped and counted.

module retire_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
endmodule

module pipeline_retire_trace #(
  parameter int DEPTH      = 8,
  parameter bit FILTER_NOP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_instr,
  input  logic                   wb_we,
  input  logic [4:0]             wb_waddr,
  input  logic [31:0]            wb_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_cycle,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [4:0]             out_class,
  output logic                   out_we,
  output logic [4:0]             out_waddr,
  output logic [31:0]            out_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [4:0] CL_NOP   = 5'd0;
  localparam logic [4:0] CL_ADD   = 5'd1;
  localparam logic [4:0] CL_SUB   = 5'd2;
  localparam logic [4:0] CL_AND   = 5'd3;
  localparam logic [4:0] CL_OR    = 5'd4;
  localparam logic [4:0] CL_SLL   = 5'd5;
  localparam logic [4:0] CL_SLT   = 5'd6;
  localparam logic [4:0] CL_MULTU = 5'd7;
  localparam logic [4:0] CL_MFHI  = 5'd8;
  localparam logic [4:0] CL_MFLO  = 5'd9;
  localparam logic [4:0] CL_LW    = 5'd10;
  localparam logic [4:0] CL_SW    = 5'd11;
  localparam logic [4:0] CL_BEQ   = 5'd12;
  localparam logic [4:0] CL_J     = 5'd13;
  localparam logic [4:0] CL_JAL   = 5'd14;
  localparam logic [4:0] CL_ADDIU = 5'd15;
  localparam logic [4:0] CL_OTHER = 5'd16;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  cls;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  logic [31:0] cycle_cnt;
  logic [4:0]  wb_class;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        is_nop;
  logic        push_req;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;
  rec_t        rec_in;
  rec_t        rec_head;

  assign op     = wb_instr[31:26];
  assign fn     = wb_instr[5:0];
  assign is_nop = (wb_instr == 32'h0);

  always_comb begin
    wb_class = CL_OTHER;
    if (is_nop) begin
      wb_class = CL_NOP;
    end else begin
      case (op)
        6'h00: begin
          case (fn)
            6'h20:   wb_class = CL_ADD;
            6'h22:   wb_class = CL_SUB;
            6'h24:   wb_class = CL_AND;
            6'h25:   wb_class = CL_OR;
            6'h00:   wb_class = CL_SLL;
            6'h2A:   wb_class = CL_SLT;
            6'h19:   wb_class = CL_MULTU;
            6'h10:   wb_class = CL_MFHI;
            6'h12:   wb_class = CL_MFLO;
            default: wb_class = CL_OTHER;
          endcase
        end
        6'h23:   wb_class = CL_LW;
        6'h2B:   wb_class = CL_SW;
        6'h04:   wb_class = CL_BEQ;
        6'h02:   wb_class = CL_J;
        6'h03:   wb_class = CL_JAL;
        6'h09:   wb_class = CL_ADDIU;
        default: wb_class = CL_OTHER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push_req  = wb_valid && !(FILTER_NOP && is_nop);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    rec_in       = '0;
    rec_in.cycle = cycle_cnt;
    rec_in.pc    = wb_pc;
    rec_in.instr = wb_instr;
    rec_in.cls   = wb_class;
    rec_in.we    = wb_we;
    rec_in.waddr = wb_waddr;
    rec_in.wdata = wb_wdata;
  end

  retire_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign out_cycle = rec_head.cycle;
  assign out_pc    = rec_head.pc;
  assign out_instr = rec_head.instr;
  assign out_class = rec_head.cls;
  assign out_we    = rec_head.we;
  assign out_waddr = rec_head.waddr;
  assign out_wdata = rec_head.wdata;
endmodule

// File: tb/tb_pipeline_retire_trace.sv
// Directed bench: instance a filters NOPs, instance b records them; both share stimulus.
module tb_pipeline_retire_trace;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_instr = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_ready = 1'b0;

  logic        a_out_valid, b_out_valid;
  logic [31:0] a_out_cycle, b_out_cycle;
  logic [31:0] a_out_pc, b_out_pc;
  logic [31:0] a_out_instr, b_out_instr;
  logic [4:0]  a_out_class, b_out_class;
  logic        a_out_we, b_out_we;
  logic [4:0]  a_out_waddr, b_out_waddr;
  logic [31:0] a_out_wdata, b_out_wdata;
  logic [3:0]  a_count, b_count;
  logic        a_overflow, b_overflow;
  logic [15:0] a_drop_count, b_drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_retire_trace #(.DEPTH(8), .FILTER_NOP(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_cycle(a_out_cycle),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .out_class(a_out_class),
    .out_we(a_out_we), .out_waddr(a_out_waddr), .out_wdata(a_out_wdata),
    .count(a_count), .overflow(a_overflow), .drop_count(a_drop_count)
  );

  pipeline_retire_trace #(.DEPTH(8), .FILTER_NOP(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_cycle(b_out_cycle),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .out_class(b_out_class),
    .out_we(b_out_we), .out_waddr(b_out_waddr), .out_wdata(b_out_wdata),
    .count(b_count), .overflow(b_overflow), .drop_count(b_drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                        input logic [4:0] waddr, input logic [31:0] wdata);
    wb_valid = 1'b1;
    wb_pc = pc;
    wb_instr = instr;
    wb_we = we;
    wb_waddr = waddr;
    wb_wdata = wdata;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  logic [31:0] sweep_instr [18];
  logic [4:0]  sweep_class [18];

  initial begin
    sweep_instr = '{32'h00000000, 32'h00851020, 32'h00851022, 32'h00851024, 32'h00851025,
                    32'h00021080, 32'h0085102A, 32'h00850019, 32'h00001010, 32'h00001012,
                    32'h8C020000, 32'hAC020000, 32'h10850003, 32'h08000010, 32'h0C000010,
                    32'h24420001, 32'h7C000000, 32'h00000021};
    sweep_class = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                    5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd16};

    // Reset state
    do_reset();
    check("rst_valid", a_out_valid, 0);
    check("rst_count", a_count, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_drops", a_drop_count, 0);

    // Basic record
    retire(32'h4, 32'h00851020, 1'b1, 5'd2, 32'd7);
    check("basic_valid", a_out_valid, 1);
    check("basic_cycle", a_out_cycle, 0);
    check("basic_pc", a_out_pc, 32'h4);
    check("basic_instr", a_out_instr, 32'h00851020);
    check("basic_class", a_out_class, 1);
    check("basic_we", a_out_we, 1);
    check("basic_waddr", a_out_waddr, 2);
    check("basic_wdata", a_out_wdata, 7);
    check("basic_count", a_count, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("basic_pop_valid", a_out_valid, 0);
    check("basic_pop_count", a_count, 0);

    // Decode sweep on the unfiltered instance, drained as it fills
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      retire(32'h1000 + 32'(4 * i), sweep_instr[i], 1'b0, 5'd0, 32'(i));
      check($sformatf("sweep_class_%0d", i), b_out_class, sweep_class[i]);
      check($sformatf("sweep_cycle_%0d", i), b_out_cycle, i);
      check($sformatf("sweep_count_%0d", i), b_count, 1);
    end
    out_ready = 1'b0;

    // NOP filter
    do_reset();
    for (int i = 0; i < 3; i++) retire(32'h2000 + 32'(4 * i), 32'h0, 1'b0, 5'd0, 32'd0);
    retire(32'h200C, 32'h00021080, 1'b1, 5'd2, 32'd9);
    check("filt_count", a_count, 1);
    check("filt_class", a_out_class, 5);
    check("filt_cycle", a_out_cycle, 3);
    check("nofilt_count", b_count, 4);

    // Overflow
    do_reset();
    for (int i = 0; i < 11; i++) retire(32'h100 + 32'(4 * i), 32'h24420000 | 32'(i), 1'b1, 5'd3, 32'(i));
    check("ovf_count", a_count, 8);
    check("ovf_flag", a_overflow, 1);
    check("ovf_drops", a_drop_count, 3);
    check("ovf_head_pc", a_out_pc, 32'h100);
    check("ovf_head_cycle", a_out_cycle, 0);
    out_ready = 1'b1;
    retire(32'h200, 32'h24420055, 1'b1, 5'd3, 32'h55);
    check("full_pp_count", a_count, 8);
    check("full_pp_drops", a_drop_count, 3);
    for (int i = 1; i < 9; i++) begin
      check($sformatf("drain_pc_%0d", i), a_out_pc, (i < 8) ? 32'h100 + 32'(4 * i) : 32'h200);
      @(negedge clk);
    end
    check("drain_valid", a_out_valid, 0);
    check("drain_overflow_sticky", a_overflow, 1);
    out_ready = 1'b0;

    // Streaming across pointer wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      retire(32'h3000 + 32'(4 * i), 32'h24420001, 1'b1, 5'd2, 32'(i));
      check($sformatf("stream_cycle_%0d", i), a_out_cycle, i);
      check($sformatf("stream_count_%0d", i), a_count, 1);
    end
    check("stream_drops", a_drop_count, 0);
    check("stream_overflow", a_overflow, 0);
    out_ready = 1'b0;

    // Async reset mid-operation
    do_reset();
    for (int i = 0; i < 10; i++) retire(32'h300 + 32'(4 * i), 32'h8C020000, 1'b1, 5'd2, 32'(i));
    check("ar_pre_drops", a_drop_count, 2);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("ar_pre_count", a_count, 5);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", a_out_valid, 0);
    check("ar_count", a_count, 0);
    check("ar_overflow", a_overflow, 0);
    check("ar_drops", a_drop_count, 0);
    #1 rst = 1'b0;
    retire(32'h400, 32'h00851020, 1'b1, 5'd2, 32'd1);
    check("ar_cycle_restart", a_out_cycle, 0);
    check("ar_pc", a_out_pc, 32'h400);
    check("ar_count_after", a_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
